// File: rtl/or1k_arb_pkg.sv
// rtl/or1k_arb_pkg.sv - shared encodings for the or1k 2:1 bus arbiter
package or1k_arb_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GNT_D = 2'd1,
    ST_GNT_I = 2'd2
  } arb_state_e;

  localparam string POLICY_DATA_FIRST  = "DATA_FIRST";
  localparam string POLICY_ROUND_ROBIN = "ROUND_ROBIN";

  localparam int GNT_IDX_D = 0;
  localparam int GNT_IDX_I = 1;
endpackage

// File: rtl/or1k_arb_watchdog.sv
// rtl/or1k_arb_watchdog.sv - ack watchdog counter with terminal-count flag
module or1k_arb_watchdog
  import or1k_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic term
);
  if (TIMEOUT_CYCLES == 0) begin : g_off
    logic unused_inputs;
    assign unused_inputs = ^{clk, rst, clr, en};
    assign term          = 1'b0;
  end else begin : g_on
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_cnt;

    always_ff @(posedge clk) begin
      if (rst || clr) begin
        wd_cnt <= '0;
      end else if (en) begin
        wd_cnt <= wd_cnt + 1'b1;
      end
    end

    assign term = (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
  end
endmodule

// File: rtl/or1k_bus_arbiter_2to1.sv
// rtl/or1k_bus_arbiter_2to1.sv - data/instruction bus arbiter in front of the wishbone bridge
module or1k_bus_arbiter_2to1
  import or1k_arb_pkg::*;
#(
  parameter string ARB_POLICY     = "DATA_FIRST",
  parameter int    BURST_MAX      = 8,
  parameter int    TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        d_req_i,
  input  logic        d_we_i,
  input  logic        d_burst_i,
  input  logic [31:0] d_adr_i,
  input  logic [31:0] d_dat_i,
  input  logic [3:0]  d_bsel_i,
  output logic        d_ack_o,
  output logic        d_err_o,
  output logic [31:0] d_dat_o,
  input  logic        i_req_i,
  input  logic        i_we_i,
  input  logic        i_burst_i,
  input  logic [31:0] i_adr_i,
  input  logic [31:0] i_dat_i,
  input  logic [3:0]  i_bsel_i,
  output logic        i_ack_o,
  output logic        i_err_o,
  output logic [31:0] i_dat_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic        bus_burst_o,
  output logic [31:0] bus_adr_o,
  output logic [31:0] bus_dat_o,
  output logic [3:0]  bus_bsel_o,
  input  logic        bus_ack_i,
  input  logic        bus_err_i,
  input  logic [31:0] bus_dat_i,
  output logic [1:0]  grant_o,
  output logic        timeout_o
);
  localparam bit RR     = (ARB_POLICY == POLICY_ROUND_ROBIN);
  localparam int BEAT_W = $clog2(BURST_MAX + 1);

  arb_state_e        state, state_nxt;
  logic              last_i, last_i_nxt;
  logic [BEAT_W-1:0] beat_cnt, beat_cnt_nxt;
  logic              granted, sel_i, x_req, x_burst, rel;
  logic              wd_term, wd_abort, wd_clr, wd_en;

  assign granted  = (state != ST_IDLE);
  assign sel_i    = (state == ST_GNT_I);
  assign x_req    = sel_i ? i_req_i   : d_req_i;
  assign x_burst  = sel_i ? i_burst_i : d_burst_i;
  // An ack or err arriving on the terminal cycle wins over the watchdog.
  assign wd_abort = granted & wd_term & ~bus_ack_i & ~bus_err_i;
  assign wd_clr   = ~granted | bus_ack_i;
  assign wd_en    = granted & ~bus_err_i;

  or1k_arb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wd (
    .clk (clk),
    .rst (rst),
    .clr (wd_clr),
    .en  (wd_en),
    .term(wd_term)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      last_i   <= 1'b1;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      last_i   <= last_i_nxt;
      beat_cnt <= beat_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    last_i_nxt   = last_i;
    beat_cnt_nxt = beat_cnt;
    rel          = 1'b0;
    case (state)
      ST_IDLE: begin
        beat_cnt_nxt = '0;
        if (d_req_i && i_req_i) begin
          state_nxt = (RR && !last_i) ? ST_GNT_I : ST_GNT_D;
        end else if (d_req_i) begin
          state_nxt = ST_GNT_D;
        end else if (i_req_i) begin
          state_nxt = ST_GNT_I;
        end
      end
      ST_GNT_D, ST_GNT_I: begin
        if (bus_ack_i) begin
          beat_cnt_nxt = beat_cnt + 1'b1;
        end
        rel = bus_err_i || wd_abort || !x_req ||
              (bus_ack_i && (!x_burst || beat_cnt == BEAT_W'(BURST_MAX - 1)));
        if (rel) begin
          state_nxt  = ST_IDLE;
          last_i_nxt = sel_i;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Everything is quiet in IDLE and while reset is held, whatever the state register says.
  always_comb begin
    bus_req_o   = 1'b0;
    bus_we_o    = 1'b0;
    bus_burst_o = 1'b0;
    bus_adr_o   = '0;
    bus_dat_o   = '0;
    bus_bsel_o  = '0;
    d_ack_o     = 1'b0;
    d_err_o     = 1'b0;
    d_dat_o     = '0;
    i_ack_o     = 1'b0;
    i_err_o     = 1'b0;
    i_dat_o     = '0;
    grant_o     = '0;
    timeout_o   = 1'b0;
    if (granted && !rst) begin
      bus_req_o          = x_req & ~wd_abort;
      bus_we_o           = sel_i ? i_we_i   : d_we_i;
      bus_burst_o        = x_burst;
      bus_adr_o          = sel_i ? i_adr_i  : d_adr_i;
      bus_dat_o          = sel_i ? i_dat_i  : d_dat_i;
      bus_bsel_o         = sel_i ? i_bsel_i : d_bsel_i;
      grant_o[GNT_IDX_I] = sel_i;
      grant_o[GNT_IDX_D] = ~sel_i;
      timeout_o          = wd_abort;
      if (sel_i) begin
        i_ack_o = bus_ack_i;
        i_err_o = bus_err_i | wd_abort;
        i_dat_o = bus_dat_i;
      end else begin
        d_ack_o = bus_ack_i;
        d_err_o = bus_err_i | wd_abort;
        d_dat_o = bus_dat_i;
      end
    end
  end
endmodule

// File: tb/tb_or1k_bus_arbiter_2to1.sv
// tb/tb_or1k_bus_arbiter_2to1.sv - bench for the or1k 2:1 bus arbiter
module tb_or1k_bus_arbiter_2to1;
  localparam int BMAX = 8;
  localparam int TMO  = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        d_req, d_we, d_burst, i_req, i_we, i_burst;
  logic [31:0] d_adr, d_dat, i_adr, i_dat;
  logic [3:0]  d_bsel, i_bsel;
  logic        bus_ack, bus_err;
  logic [31:0] bus_rdat;

  logic        df_d_ack, df_d_err, df_i_ack, df_i_err, df_breq, df_bwe, df_bburst, df_tmo;
  logic [31:0] df_d_dat, df_i_dat, df_badr, df_bdat;
  logic [3:0]  df_bsel;
  logic [1:0]  df_grant;
  logic        rr_d_ack, rr_d_err, rr_i_ack, rr_i_err, rr_breq, rr_bwe, rr_bburst, rr_tmo;
  logic [31:0] rr_d_dat, rr_i_dat, rr_badr, rr_bdat;
  logic [3:0]  rr_bsel;
  logic [1:0]  rr_grant;

  int total = 0;
  int bad   = 0;

  or1k_bus_arbiter_2to1 #(.ARB_POLICY("DATA_FIRST"), .BURST_MAX(BMAX), .TIMEOUT_CYCLES(TMO)) u_df (
    .clk(clk), .rst(rst),
    .d_req_i(d_req), .d_we_i(d_we), .d_burst_i(d_burst), .d_adr_i(d_adr), .d_dat_i(d_dat),
    .d_bsel_i(d_bsel), .d_ack_o(df_d_ack), .d_err_o(df_d_err), .d_dat_o(df_d_dat),
    .i_req_i(i_req), .i_we_i(i_we), .i_burst_i(i_burst), .i_adr_i(i_adr), .i_dat_i(i_dat),
    .i_bsel_i(i_bsel), .i_ack_o(df_i_ack), .i_err_o(df_i_err), .i_dat_o(df_i_dat),
    .bus_req_o(df_breq), .bus_we_o(df_bwe), .bus_burst_o(df_bburst), .bus_adr_o(df_badr),
    .bus_dat_o(df_bdat), .bus_bsel_o(df_bsel), .bus_ack_i(bus_ack), .bus_err_i(bus_err),
    .bus_dat_i(bus_rdat), .grant_o(df_grant), .timeout_o(df_tmo)
  );

  or1k_bus_arbiter_2to1 #(.ARB_POLICY("ROUND_ROBIN"), .BURST_MAX(BMAX), .TIMEOUT_CYCLES(TMO)) u_rr (
    .clk(clk), .rst(rst),
    .d_req_i(d_req), .d_we_i(d_we), .d_burst_i(d_burst), .d_adr_i(d_adr), .d_dat_i(d_dat),
    .d_bsel_i(d_bsel), .d_ack_o(rr_d_ack), .d_err_o(rr_d_err), .d_dat_o(rr_d_dat),
    .i_req_i(i_req), .i_we_i(i_we), .i_burst_i(i_burst), .i_adr_i(i_adr), .i_dat_i(i_dat),
    .i_bsel_i(i_bsel), .i_ack_o(rr_i_ack), .i_err_o(rr_i_err), .i_dat_o(rr_i_dat),
    .bus_req_o(rr_breq), .bus_we_o(rr_bwe), .bus_burst_o(rr_bburst), .bus_adr_o(rr_badr),
    .bus_dat_o(rr_bdat), .bus_bsel_o(rr_bsel), .bus_ack_i(bus_ack), .bus_err_i(bus_err),
    .bus_dat_i(bus_rdat), .grant_o(rr_grant), .timeout_o(rr_tmo)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    d_req = 1'b0; d_we = 1'b0; d_burst = 1'b0; d_adr = '0; d_dat = '0; d_bsel = '0;
    i_req = 1'b0; i_we = 1'b0; i_burst = 1'b0; i_adr = '0; i_dat = '0; i_bsel = '0;
    bus_ack = 1'b0; bus_err = 1'b0; bus_rdat = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int rr_next;
    int rr_cnt_d;
    int rr_cnt_i;
    logic [1:0] exp_g;

    // reset: outputs silent even with requests and bus responses asserted
    idle_inputs();
    rst = 1'b1;
    tick();
    d_req = 1'b1; i_req = 1'b1; bus_ack = 1'b1; bus_err = 1'b1;
    #1;
    chk2("rst_grant", df_grant, 2'b00);
    chk1("rst_breq", df_breq, 1'b0);
    chk1("rst_dack", df_d_ack, 1'b0);
    chk1("rst_derr", df_d_err, 1'b0);
    chk1("rst_tmo", df_tmo, 1'b0);
    tick();
    idle_inputs();
    bus_ack = 1'b1;
    rst = 1'b0;
    #1;
    chk1("idle_dack", df_d_ack, 1'b0);
    chk2("idle_grant", df_grant, 2'b00);

    // D-only single read
    do_reset();
    d_req = 1'b1; d_adr = 32'h100; d_we = 1'b0; d_bsel = 4'hF; d_dat = $urandom;
    #1;
    chk2("t1_req_seen_grant", df_grant, 2'b00);
    tick();
    #1;
    chk2("t1_grant", df_grant, 2'b01);
    chk1("t1_breq", df_breq, 1'b1);
    chk32("t1_badr", df_badr, 32'h100);
    chk32("t1_bdat", df_bdat, d_dat);
    chk32("t1_bsel", {28'b0, df_bsel}, 32'hF);
    chk1("t1_no_ack_yet", df_d_ack, 1'b0);
    tick();
    bus_ack = 1'b1; bus_rdat = $urandom;
    #1;
    chk1("t1_dack", df_d_ack, 1'b1);
    chk32("t1_ddat", df_d_dat, bus_rdat);
    chk1("t1_iack", df_i_ack, 1'b0);
    chk32("t1_idat", df_i_dat, 32'h0);
    tick();
    bus_ack = 1'b0; d_req = 1'b0;
    #1;
    chk2("t1_release", df_grant, 2'b00);

    // DATA_FIRST tie, both single-beat, each requester drops after its ack
    do_reset();
    d_req = 1'b1; i_req = 1'b1; bus_ack = 1'b1;
    d_adr = $urandom; i_adr = $urandom;
    #1;
    chk2("t2_c0", df_grant, 2'b00);
    tick(); #1;
    chk2("t2_c1", df_grant, 2'b01);
    chk1("t2_c1_dack", df_d_ack, 1'b1);
    chk1("t2_c1_iack", df_i_ack, 1'b0);
    chk32("t2_c1_adr", df_badr, d_adr);
    tick();
    d_req = 1'b0;
    #1;
    chk2("t2_c2", df_grant, 2'b00);
    tick(); #1;
    chk2("t2_c3", df_grant, 2'b10);
    chk1("t2_c3_iack", df_i_ack, 1'b1);
    chk1("t2_c3_dack", df_d_ack, 1'b0);
    chk32("t2_c3_adr", df_badr, i_adr);
    tick();
    i_req = 1'b0;
    #1;
    chk2("t2_c4", df_grant, 2'b00);

    // both hammering: round robin alternates, data-first always picks D
    do_reset();
    d_req = 1'b1; i_req = 1'b1; bus_ack = 1'b1;
    rr_next = 0; rr_cnt_d = 0; rr_cnt_i = 0;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (c % 2 == 0) begin
        chk2("t3_rr_idle", rr_grant, 2'b00);
        chk2("t3_df_idle", df_grant, 2'b00);
      end else begin
        exp_g = (rr_next == 0) ? 2'b01 : 2'b10;
        chk2("t3_rr_grant", rr_grant, exp_g);
        chk2("t3_df_grant", df_grant, 2'b01);
        if (rr_grant == 2'b01) rr_cnt_d++;
        if (rr_grant == 2'b10) rr_cnt_i++;
        rr_next = 1 - rr_next;
      end
      tick();
    end
    chk32("t3_rr_d_count", rr_cnt_d, 3);
    chk32("t3_rr_i_count", rr_cnt_i, 3);

    // I burst capped at BMAX beats, then one IDLE, then the pending D
    do_reset();
    i_req = 1'b1; i_burst = 1'b1; bus_ack = 1'b1;
    tick();
    d_req = 1'b1;
    for (int k = 0; k < BMAX; k++) begin
      #1;
      chk2("t4_burst_grant", df_grant, 2'b10);
      chk1("t4_burst_iack", df_i_ack, 1'b1);
      chk1("t4_burst_dack", df_d_ack, 1'b0);
      tick();
    end
    #1;
    chk2("t4_gap", df_grant, 2'b00);
    tick(); #1;
    chk2("t4_d_next", df_grant, 2'b01);
    chk1("t4_d_ack", df_d_ack, 1'b1);
    idle_inputs();
    tick();

    // slave never answers: watchdog fires on cycle TMO of the grant
    do_reset();
    d_req = 1'b1;
    tick();
    for (int k = 1; k < TMO; k++) begin
      #1;
      chk1("t5_wait_tmo", df_tmo, 1'b0);
      chk1("t5_wait_err", df_d_err, 1'b0);
      tick();
    end
    #1;
    chk1("t5_derr", df_d_err, 1'b1);
    chk1("t5_tmo", df_tmo, 1'b1);
    chk1("t5_breq", df_breq, 1'b0);
    chk1("t5_ierr", df_i_err, 1'b0);
    tick(); #1;
    chk2("t5_after", df_grant, 2'b00);
    chk1("t5_tmo_pulse", df_tmo, 1'b0);
    idle_inputs();
    tick();

    // reset asserted at beat 4 of an I burst
    do_reset();
    i_req = 1'b1; i_burst = 1'b1; bus_ack = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      #1;
      chk1("t6_beat_iack", df_i_ack, 1'b1);
      tick();
    end
    rst = 1'b1;
    #1;
    chk1("t6_rst_iack", df_i_ack, 1'b0);
    chk1("t6_rst_breq", df_breq, 1'b0);
    tick();
    rst = 1'b0;
    #1;
    chk2("t6_post_grant", df_grant, 2'b00);
    chk1("t6_post_breq", df_breq, 1'b0);
    chk1("t6_post_iack", df_i_ack, 1'b0);
    idle_inputs();
    tick();

    // ack and err together inside a burst: err forwarded, grant dropped
    do_reset();
    d_req = 1'b1; d_burst = 1'b1;
    tick();
    bus_ack = 1'b1; bus_err = 1'b1;
    #1;
    chk1("t7_derr", df_d_err, 1'b1);
    chk1("t7_dack", df_d_ack, 1'b1);
    tick();
    bus_ack = 1'b0; bus_err = 1'b0;
    #1;
    chk2("t7_release", df_grant, 2'b00);
    idle_inputs();
    tick();

    // random-length D bursts with random ack spacing, split into grants of at most BMAX beats
    do_reset();
    for (int t = 0; t < 8; t++) begin
      int len, done, acnt, gap, budget, ngr, want;
      int q[$];
      logic [1:0] prev_g;
      len = $urandom_range(1, 20);
      done = 0; acnt = 0; budget = 0; prev_g = 2'b00;
      gap = $urandom_range(0, 3);
      q.delete();
      while (budget < 300) begin
        budget++;
        if (prev_g == 2'b01 && df_grant != 2'b01) begin
          q.push_back(acnt);
          acnt = 0;
        end
        prev_g = df_grant;
        if (done >= len && df_grant != 2'b01) break;
        d_req = (done < len);
        d_burst = (done < len - 1);
        d_adr = 32'h2000 + 32'(done * 4);
        bus_ack = 1'b0;
        #1;
        if (df_grant == 2'b01) begin
          if (gap == 0) begin
            bus_ack = 1'b1;
            bus_rdat = $urandom;
            gap = $urandom_range(0, 3);
          end else begin
            gap--;
          end
        end
        #1;
        if (bus_ack) begin
          chk1("rnd_dack", df_d_ack, 1'b1);
          chk32("rnd_ddat", df_d_dat, bus_rdat);
          chk32("rnd_badr", df_badr, d_adr);
          done++;
          acnt++;
        end
        tick();
      end
      idle_inputs();
      chk32("rnd_done", done, len);
      ngr = (len + BMAX - 1) / BMAX;
      chk32("rnd_ngrants", q.size(), ngr);
      for (int g = 0; g < q.size() && g < ngr; g++) begin
        want = (len - g * BMAX > BMAX) ? BMAX : len - g * BMAX;
        chk32("rnd_beats", q[g], want);
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/or1k_bus_arbiter_2to1.md
Name: or1k_bus_arbiter_2to1

Overview:
- Two-requester arbiter sharing one CPU-side bus port between the or1k data bus (D) and instruction bus (I).
- Sits between the LSU/fetch units and the single Wishbone bus bridge.
- Sequences grants per transaction and holds the grant through bursts.
- Enforces a burst-length cap and an ack watchdog so a stalled slave cannot hang the core.

Parameters:
- ARB_POLICY, "DATA_FIRST", "DATA_FIRST" = D always wins a tie; "ROUND_ROBIN" = tie goes to the requester not granted last.
- BURST_MAX, 8, maximum acks per held grant before forced release. Legal values: 1-16.
- TIMEOUT_CYCLES, 1024, cycles without ack/err before abort. 0 disables the watchdog.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- d_req_i, d_we_i, d_burst_i  in  1 each  data requester request, write, burst-continue
- d_adr_i, d_dat_i  in  32 each  data requester address, write data
- d_bsel_i  in  4  data requester byte select
- d_ack_o, d_err_o  out  1 each  completion to data requester
- d_dat_o  out  32  read data to data requester
- i_req_i, i_we_i, i_burst_i, i_adr_i, i_dat_i, i_bsel_i, i_ack_o, i_err_o, i_dat_o  same widths/meaning for the instruction requester
- bus_req_o, bus_we_o, bus_burst_o  out  1 each  to bridge
- bus_adr_o, bus_dat_o  out  32 each  to bridge
- bus_bsel_o  out  4  to bridge
- bus_ack_i, bus_err_i  in  1 each  from bridge
- bus_dat_i  in  32  from bridge
- grant_o  out  2  {I,D} one-hot current grant, 00 when idle
- timeout_o  out  1  single-cycle pulse on watchdog abort

Behaviour:
- States: IDLE, GNT_D, GNT_I. Reset → IDLE, last_grant=I (so D wins the first round-robin tie), counters 0.
- All outputs 0 in reset and in IDLE.
- IDLE: registered arbitration, so a grant takes effect the cycle after a request is seen.
  - Only one request: grant it.
  - Both requesting: DATA_FIRST → GNT_D; ROUND_ROBIN → requester != last_grant.
- GNT_x output muxing:
  - Bus outputs = requester x's inputs; bus_req_o = x_req_i.
  - x_ack_o = bus_ack_i, x_err_o = bus_err_i, x_dat_o = bus_dat_i.
  - Non-granted requester sees ack/err/dat = 0.
- Each bus_ack_i in GNT_x increments beat_cnt.
- Release from GNT_x to IDLE and update last_grant=x when any of:
  - bus_err_i;
  - bus_ack_i with x_burst_i=0;
  - bus_ack_i with beat_cnt==BURST_MAX-1;
  - x_req_i=0 (abort with no ack: release, no ack/err generated).
- Otherwise remain granted. bus_ack_i with x_burst_i=1 and cap not reached continues the burst.
- One guaranteed IDLE cycle between grants, including back-to-back transactions from the same requester. This lets the bridge's cycle-end logic settle.
- Watchdog:
  - wd_cnt clears on grant and on every ack.
  - Increments each GNT_x cycle without ack/err.
  - On reaching TIMEOUT_CYCLES-1: x_err_o=1 for that cycle (combinational with wd terminal), timeout_o=1, bus_req_o forced 0 that cycle, → IDLE.
- Simultaneous bus_ack_i and bus_err_i: err takes priority. Ack still routes, but the grant is released.
- Reset mid-transaction: synchronous return to IDLE next edge; bus_req_o drops and no ack/err is forwarded.
- Widths:
  - beat_cnt is $clog2(BURST_MAX+1) bits, saturating never needed because release happens at the cap.
  - wd_cnt is $clog2(TIMEOUT_CYCLES+1) bits.

Decomposition:
- Shared package or1k_arb_pkg:
  - state encoding constants (IDLE/GNT_D/GNT_I);
  - policy string constants;
  - grant index constants (GNT_IDX_D=0, GNT_IDX_I=1).
- Sub-module or1k_arb_watchdog: counter, clear/enable inputs, terminal-count output. Tied off when TIMEOUT_CYCLES=0.
- Muxing and FSM stay in the top.

Test Plan:
- D-only single read: d_req_i=1, adr=0x100, ack after 2 cycles.
  - grant_o=01 one cycle after req; d_ack_o pulses with d_dat_o=bus_dat_i; grant_o=00 next cycle; i_ack_o stays 0.
- Simultaneous D and I requests, DATA_FIRST, both single-beat.
  - Order D, IDLE, I, IDLE; grant_o 01,00,10,00.
- Same case with ROUND_ROBIN, D re-requests continuously.
  - Grants alternate D, I, D, …; neither starves across 6 transactions.
- I burst with i_burst_i=1 held, BURST_MAX=8, ack every cycle.
  - Exactly 8 acks under GNT_I, then IDLE one cycle; pending D granted next.
- Slave never acks, TIMEOUT_CYCLES=16.
  - On cycle 16 of the grant: d_err_o=1 and timeout_o=1 for one cycle; bus_req_o=0; grant_o=00 next.
- rst asserted mid-burst at beat 3.
  - All outputs 0 next cycle, state IDLE, no further acks forwarded.
- Also cover: ack+err in the same cycle → err seen, grant released.
